// File: rtl/burst_seq_ctrl.sv
// Burst sequencer: loads a downstream counter with the start address, then steps it once per accepted beat.
// Optional BURST_WRAP_EN adds i_wrap_end; a non-last beat at that address reloads the start instead of counting.
module burst_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [WIDTH-1:0] i_start_addr,
  input  logic [LEN_W-1:0] i_length,
  output logic             o_set_en,
  output logic [WIDTH-1:0] o_set_data,
  output logic             o_count_en,
  input  logic [WIDTH-1:0] i_number,
  output logic [WIDTH-1:0] o_addr,
  output logic             o_addr_valid,
  input  logic             i_beat_ready,
  output logic             o_last,
  output logic             o_done,
  output logic             o_busy
`ifdef BURST_WRAP_EN
  ,
  input  logic [WIDTH-1:0] i_wrap_end
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             beat_acc;
  logic             wrap_hit;

  assign beat_acc = valid_q & i_beat_ready;

`ifdef BURST_WRAP_EN
  // The final beat never reloads: the burst ends there regardless of the window.
  assign wrap_hit = beat_acc & ~last_q & (i_number == i_wrap_end);
`else
  assign wrap_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          if (i_length == '0) begin
            state_d = DONE;
          end else begin
            start_d = i_start_addr;
            rem_d   = i_length;
            state_d = LOAD;
          end
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (beat_acc) begin
          rem_d = rem_q - 1'b1;
          if (last_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Output flags are registered from the next state so they line up with state_q.
    valid_d = (state_d == RUN);
    last_d  = (state_d == RUN) && (rem_d == LEN_W'(1));
    done_d  = (state_d == DONE);
    load_d  = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
    end
  end

  assign o_req_ready  = rst_n & (state_q == IDLE);
  assign o_addr       = i_number;
  assign o_addr_valid = valid_q;
  assign o_last       = last_q;
  assign o_done       = done_q;
  assign o_busy       = busy_q;
  assign o_count_en   = beat_acc & ~wrap_hit;
  assign o_set_en     = load_q | wrap_hit;
  assign o_set_data   = o_set_en ? start_q : '0;

endmodule

// File: tb/tb_burst_seq_ctrl.sv
// Scoreboard bench for burst_seq_ctrl with a behavioural loadable counter closing the feedback loop.
module tb_burst_seq_ctrl;
  localparam int W = 8;
  localparam int L = 8;
  localparam int EV_ACC = 0, EV_SET = 1, EV_BEAT = 2, EV_DONE = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_req_valid = 1'b0;
  logic         o_req_ready;
  logic [W-1:0] i_start_addr = '0;
  logic [L-1:0] i_length = '0;
  logic         o_set_en;
  logic [W-1:0] o_set_data;
  logic         o_count_en;
  logic [W-1:0] cnt_q;
  logic [W-1:0] o_addr;
  logic         o_addr_valid;
  logic         i_beat_ready = 1'b0;
  logic         o_last;
  logic         o_done;
  logic         o_busy;
`ifdef BURST_WRAP_EN
  logic [W-1:0] i_wrap_end = 8'h80;
`endif

  burst_seq_ctrl #(.WIDTH(W), .LEN_W(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_start_addr(i_start_addr), .i_length(i_length),
    .o_set_en(o_set_en), .o_set_data(o_set_data), .o_count_en(o_count_en),
    .i_number(cnt_q), .o_addr(o_addr), .o_addr_valid(o_addr_valid),
    .i_beat_ready(i_beat_ready), .o_last(o_last), .o_done(o_done), .o_busy(o_busy)
`ifdef BURST_WRAP_EN
    , .i_wrap_end(i_wrap_end)
`endif
  );

  always #5 clk = ~clk;

  // Downstream loadable counter
  always @(posedge clk) begin
    if (!rst_n)          cnt_q <= '0;
    else if (o_set_en)   cnt_q <= o_set_data;
    else if (o_count_en) cnt_q <= cnt_q + 1'b1;
  end

  typedef struct {
    int           kind;
    logic [W-1:0] val;
    logic         last;
    int           dt;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  last_cyc = 0;

  function automatic void push(int k, logic [W-1:0] v, logic l, int dt);
    exp_q.push_back('{kind: k, val: v, last: l, dt: dt});
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic log_ev(int k, logic [W-1:0] v, logic l);
    int  dt;
    ev_t e;
    dt = cyc - last_cyc;
    last_cyc = cyc;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d val=%0h last=%0b, required none", k, v, l);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.val !== v || e.last !== l || (e.dt >= 0 && e.dt != dt)) begin
      n_err++;
      $display("FAIL event: got kind=%0d val=%0h last=%0b dt=%0d, required kind=%0d val=%0h last=%0b dt=%0d",
               k, v, l, dt, e.kind, e.val, e.last, e.dt);
    end
  endtask

  // Monitor: events are ordered accept, beat, set, done within one cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (o_set_en || o_count_en) chk("strobe_exclusive", {31'd0, o_set_en & o_count_en}, 32'd0);
      if (o_addr_valid) chk("count_en", {31'd0, o_count_en}, {31'd0, i_beat_ready & ~o_set_en});
      if (i_req_valid && o_req_ready) log_ev(EV_ACC, '0, 1'b0);
      if (o_addr_valid && i_beat_ready) log_ev(EV_BEAT, o_addr, o_last);
      if (o_set_en) log_ev(EV_SET, o_set_data, 1'b0);
      if (o_done) log_ev(EV_DONE, '0, 1'b0);
    end
  end

  // rdy[k] drives i_beat_ready in cycle k after the accept cycle (cycle 1 is LOAD).
  task automatic issue(logic [W-1:0] sa, logic [L-1:0] len, logic [15:0] rdy, int ncyc);
    @(posedge clk); #1;
    i_req_valid  = 1'b1;
    i_start_addr = sa;
    i_length     = len;
    i_beat_ready = rdy[0];
    for (int t = 0; t < 20 && !o_req_ready; t++) @(negedge clk);
    chk("req_ready_wait", {31'd0, o_req_ready}, 32'd1);
    if (!o_req_ready) begin
      i_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      i_beat_ready = rdy[k];
      @(posedge clk); #1;
    end
    i_beat_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, o_req_ready}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_set_en", {31'd0, o_set_en}, 32'd0);
    chk("rst_set_data", {24'd0, o_set_data}, 32'd0);
    chk("rst_count_en", {31'd0, o_count_en}, 32'd0);
    chk("rst_addr_valid", {31'd0, o_addr_valid}, 32'd0);
    chk("rst_last", {31'd0, o_last}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, o_req_ready}, 32'd1);

    // Basic burst, full throughput
    push(EV_ACC, 8'h00, 0, -1); push(EV_SET, 8'h10, 0, 1);
    push(EV_BEAT, 8'h10, 0, 1); push(EV_BEAT, 8'h11, 0, 1);
    push(EV_BEAT, 8'h12, 0, 1); push(EV_BEAT, 8'h13, 1, 1);
    push(EV_DONE, 8'h00, 0, 1);
    issue(8'h10, 8'd4, 16'hFFFF, 7);

    // Stalled beats: ready 1,0,1,0,1 across the RUN cycles
    push(EV_ACC, 8'h00, 0, -1); push(EV_SET, 8'h10, 0, 1);
    push(EV_BEAT, 8'h10, 0, 1); push(EV_BEAT, 8'h11, 0, 2);
    push(EV_BEAT, 8'h12, 1, 2); push(EV_DONE, 8'h00, 0, 1);
    issue(8'h10, 8'd3, 16'h0054, 8);

    // Empty burst
    push(EV_ACC, 8'h00, 0, -1); push(EV_DONE, 8'h00, 0, 1);
    issue(8'h33, 8'd0, 16'hFFFF, 3);

    // Counter wrap through 0xFF
    push(EV_ACC, 8'h00, 0, -1); push(EV_SET, 8'hFE, 0, 1);
    push(EV_BEAT, 8'hFE, 0, 1); push(EV_BEAT, 8'hFF, 0, 1);
    push(EV_BEAT, 8'h00, 0, 1); push(EV_BEAT, 8'h01, 1, 1);
    push(EV_DONE, 8'h00, 0, 1);
    issue(8'hFE, 8'd4, 16'hFFFF, 7);

`ifdef BURST_WRAP_EN
    i_wrap_end = 8'h11;
    push(EV_ACC, 8'h00, 0, -1); push(EV_SET, 8'h10, 0, 1);
    push(EV_BEAT, 8'h10, 0, 1); push(EV_BEAT, 8'h11, 0, 1); push(EV_SET, 8'h10, 0, 0);
    push(EV_BEAT, 8'h10, 0, 1); push(EV_BEAT, 8'h11, 0, 1); push(EV_SET, 8'h10, 0, 0);
    push(EV_BEAT, 8'h10, 1, 1); push(EV_DONE, 8'h00, 0, 1);
    issue(8'h10, 8'd5, 16'hFFFF, 8);
    i_wrap_end = 8'h80;
`endif

    // Reset during the second beat: burst abandoned, no done
    push(EV_ACC, 8'h00, 0, -1); push(EV_SET, 8'h20, 0, 1);
    push(EV_BEAT, 8'h20, 0, 1);
    @(posedge clk); #1;
    i_req_valid  = 1'b1;
    i_start_addr = 8'h20;
    i_length     = 8'd4;
    i_beat_ready = 1'b1;
    @(negedge clk);
    chk("rst_test_ready", {31'd0, o_req_ready}, 32'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready_low", {31'd0, o_req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_addr_valid", {31'd0, o_addr_valid}, 32'd0);
    chk("midrst_done", {31'd0, o_done}, 32'd0);
    rst_n = 1'b1;
    i_beat_ready = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", {31'd0, o_req_ready}, 32'd1);
    repeat (5) @(negedge clk);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
